uart_tx_frame: RTL and testbench

Serial UART transmitter and the TX-side counterpart of the receiver's parity checker. It accepts a parallel byte with a one-cycle valid strobe and serialises it LSB first onto TX_OUT. The frame is a start bit, the data bits, an optional even/odd parity bit and a stop bit. The block sits in the TX clock domain of the UART, fed by the system/FIFO side. Its parity rule matches the receiver's check exactly.

---
 rtl/uart_tx_frame.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmitter: start, LSB-first data, optional parity, stop.
// Optional second stop bit when UART_TX_STOP2_EN is defined (adds STOP2 input).
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
`ifdef UART_TX_STOP2_EN
  input  logic                  STOP2,
`endif
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int          IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [7:0]  DIV_LAST = 8'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic [7:0]            div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  bit_done;
`ifdef UART_TX_STOP2_EN
  logic                  stop2_q, stop2_d;
  logic                  stop_half_q, stop_half_d;
`endif

  // Divider is bypassed entirely at one cycle per bit.
  assign bit_done = (BIT_CYCLES == 1) ? 1'b1 : (div_q == DIV_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      div_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
`ifdef UART_TX_STOP2_EN
      stop2_q     <= 1'b0;
      stop_half_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      par_en_q    <= par_en_d;
      par_bit_q   <= par_bit_d;
`ifdef UART_TX_STOP2_EN
      stop2_q     <= stop2_d;
      stop_half_q <= stop_half_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    div_d       = div_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
`ifdef UART_TX_STOP2_EN
    stop2_d     = stop2_q;
    stop_half_d = stop_half_q;
`endif
    if (state_q != IDLE) begin
      div_d = bit_done ? 8'd0 : div_q + 8'd1;
    end

    // tx_d is the value of the bit that starts at this edge.
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        div_d  = '0;
        if (Data_Valid) begin
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          shreg_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = (^P_DATA) ^ PAR_TYP;
`ifdef UART_TX_STOP2_EN
          stop2_d     = STOP2;
          stop_half_d = 1'b0;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IDX_ONE;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
`ifdef UART_TX_STOP2_EN
          if (stop2_q && !stop_half_q) begin
            stop_half_d = 1'b1;
          end else begin
            stop_half_d = 1'b0;
            state_d     = IDLE;
            busy_d      = 1'b0;
          end
`else
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - randomized frame-level check of uart_tx_frame at 1 and 4 cycles per bit.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       dv1, dv4;
  logic       par_en, par_typ;
  logic       tx1, busy1, tx4, busy4;
`ifdef UART_TX_STOP2_EN
  logic       stop2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(8), .BIT_CYCLES(1)) u_dut1 (
    .CLK(clk), .RST(rst), .P_DATA(p_data), .Data_Valid(dv1),
    .PAR_EN(par_en), .PAR_TYP(par_typ),
`ifdef UART_TX_STOP2_EN
    .STOP2(stop2),
`endif
    .TX_OUT(tx1), .busy(busy1)
  );

  uart_tx_frame #(.DATA_WIDTH(8), .BIT_CYCLES(4)) u_dut4 (
    .CLK(clk), .RST(rst), .P_DATA(p_data), .Data_Valid(dv4),
    .PAR_EN(par_en), .PAR_TYP(par_typ),
`ifdef UART_TX_STOP2_EN
    .STOP2(stop2),
`endif
    .TX_OUT(tx4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference frame: list of line levels, one entry per bit time.
  function automatic void build_frame(input logic [7:0] d, input bit pen, input bit ptyp,
                                      input bit s2, output bit bits[$]);
    int ones = 0;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pen) bits.push_back(ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1));
    bits.push_back(1'b1);
`ifdef UART_TX_STOP2_EN
    if (s2) bits.push_back(1'b1);
`else
    if (s2) begin end
`endif
  endfunction

  // Called at a negedge; returns at the negedge where busy must be low again.
  task automatic run_frame(input string name, input bit wide, input logic [7:0] d,
                           input bit pen, input bit ptyp, input bit s2, input bit noise);
    bit bits[$];
    int b = wide ? 4 : 1;
    build_frame(d, pen, ptyp, s2, bits);
    p_data  = d;
    par_en  = pen;
    par_typ = ptyp;
`ifdef UART_TX_STOP2_EN
    stop2 = s2;
`endif
    if (wide) dv4 = 1'b1; else dv1 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < bits.size() * b; i++) begin
      check($sformatf("%s tx[%0d]", name, i), wide ? tx4 : tx1, bits[i / b]);
      check($sformatf("%s busy[%0d]", name, i), wide ? busy4 : busy1, 1);
      dv1 = 1'b0;
      dv4 = 1'b0;
      if (noise) begin
        p_data  = 8'($urandom);
        par_en  = ~par_en;
        par_typ = ~par_typ;
        if (i == 3) begin
          p_data = 8'h33;
          if (wide) dv4 = 1'b1; else dv1 = 1'b1;
        end
      end
      @(negedge clk);
    end
    dv1 = 1'b0;
    dv4 = 1'b0;
    check({name, " idle tx"}, wide ? tx4 : tx1, 1);
    check({name, " idle busy"}, wide ? busy4 : busy1, 0);
  endtask

  initial begin
    rst = 1'b1; dv1 = 1'b0; dv4 = 1'b0;
    p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0;
`ifdef UART_TX_STOP2_EN
    stop2 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset tx1", tx1, 1);
    check("reset busy1", busy1, 0);
    check("reset tx4", tx4, 1);
    check("reset busy4", busy4, 0);
    rst = 1'b0;
    @(negedge clk);

    run_frame("a5_even", 0, 8'hA5, 1, 0, 0, 0);
    run_frame("01_odd", 0, 8'h01, 1, 1, 0, 0);
    run_frame("03_odd", 0, 8'h03, 1, 1, 0, 0);
    run_frame("ff_nopar", 0, 8'hFF, 0, 0, 0, 0);
    run_frame("5a_div4", 1, 8'h5A, 1, 0, 0, 0);
    run_frame("a5_noise", 0, 8'hA5, 1, 0, 0, 1);
    run_frame("b2b", 0, 8'h3C, 1, 1, 0, 0);
    run_frame("a5_noise4", 1, 8'hA5, 1, 1, 0, 1);
    run_frame("stop2", 0, 8'h96, 1, 0, 1, 0);

    for (int n = 0; n < 24; n++) begin
      run_frame($sformatf("rnd%0d", n), 0, 8'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    for (int n = 0; n < 6; n++) begin
      run_frame($sformatf("rnd4_%0d", n), 1, 8'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom));
    end

    // Abort a frame while data bit 4 is on the line.
    p_data = 8'hF0; par_en = 1'b1; par_typ = 1'b0; dv1 = 1'b1;
    @(negedge clk);
    dv1 = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst bit4", tx1, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst tx", tx1, 1);
    check("mid_rst busy", busy1, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst tx", tx1, 1);
    check("post_rst busy", busy1, 0);
    run_frame("c3_after_rst", 0, 8'hC3, 1, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
